// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates fetch (F) and memory-stage (M) requests onto one
//            shared single-port memory. IDLE -> BUSY -> RESP handshake with
//            range checking, BUSY timeout and a sticky ADR status.
// Option   : `define ARB_ROUND_ROBIN_EN for alternating arbitration on
//            simultaneous requests; default is fixed M-over-F priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_LIMIT = 1024,
  parameter int TIMEOUT    = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ack,
  output logic [63:0] f_rdata,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_ack,
  output logic [63:0] m_rdata,
  output logic        m_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  stat
);

  localparam logic [1:0]  c_idle     = 2'd0;
  localparam logic [1:0]  c_busy     = 2'd1;
  localparam logic [1:0]  c_resp     = 2'd2;
  localparam logic        c_own_f    = 1'b0;
  localparam logic        c_own_m    = 1'b1;
  localparam int          c_cnt_w    = $clog2(TIMEOUT + 1);
  // Highest legal start address of an 8-byte access; anything above it
  // either crosses ADDR_LIMIT or wrapped around 2^64.
  localparam logic [63:0] c_max_addr = 64'(ADDR_LIMIT - 8);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_owner;
  logic [63:0]        r_addr;
  logic [63:0]        r_wdata;
  logic               r_we;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;
  logic               r_stat_adr;
  logic [63:0]        r_f_rdata;
  logic [63:0]        r_m_rdata;
  logic               w_any_req;
  logic               w_grant_m;
  logic [63:0]        w_sel_addr;
  logic               w_range_err;
  logic               w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when M should win the next tie; flips to the other side in RESP.
  logic r_prio_m;

  // Alternating winner on simultaneous requests
  always_comb begin
    w_grant_m = m_req & (~f_req | r_prio_m);
  end

  // Last-granted pointer, updated once per completed transaction
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_prio_m <= 1'b1;
    end else if (r_state == c_resp) begin
      r_prio_m <= (r_owner == c_own_f);
    end
  end
`else
  // Fixed priority: memory stage always beats fetch
  always_comb begin
    w_grant_m = m_req;
  end
`endif

  // Request decode, range check and BUSY timeout detection
  always_comb begin
    w_any_req   = m_req | f_req;
    w_sel_addr  = w_grant_m ? m_addr : f_addr;
    w_range_err = (w_sel_addr > c_max_addr);
    w_timeout   = (r_cnt == c_cnt_last) && !mem_ready;
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; requests are not looked at outside IDLE
  always_comb begin
    w_next_state = c_idle;
    case (r_state)
      c_idle: begin
        if (w_any_req) begin
          w_next_state = w_range_err ? c_resp : c_busy;
        end
      end
      c_busy: begin
        w_next_state = (mem_ready || w_timeout) ? c_resp : c_busy;
      end
      c_resp:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Transaction latch, BUSY counter, read data capture and sticky status
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_owner    <= c_own_m;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_stat_adr <= 1'b0;
      r_f_rdata  <= '0;
      r_m_rdata  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any_req) begin
            r_owner <= w_grant_m ? c_own_m : c_own_f;
            r_addr  <= w_sel_addr;
            r_we    <= w_grant_m & m_we;
            r_wdata <= w_grant_m ? m_wdata : 64'd0;
            r_err   <= w_range_err;
            r_cnt   <= '0;
            if (w_range_err) begin
              r_stat_adr <= 1'b1;
            end
          end
        end
        c_busy: begin
          if (mem_ready) begin
            r_err <= 1'b0;
            if (r_owner == c_own_f) begin
              r_f_rdata <= mem_rdata;
            end else if (!r_we) begin
              r_m_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_stat_adr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and latched transaction
  always_comb begin
    mem_en    = (r_state == c_busy);
    mem_we    = mem_en & r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    f_ack     = (r_state == c_resp) && (r_owner == c_own_f);
    m_ack     = (r_state == c_resp) && (r_owner == c_own_m);
    f_err     = f_ack & r_err;
    m_err     = m_ack & r_err;
    f_rdata   = r_f_rdata;
    m_rdata   = r_m_rdata;
    stat      = {r_stat_adr, 1'b0};
  end

endmodule
`default_nettype wire
